// File: rtl/masked_hpc3_and_chain_pkg.sv
// Shared helpers for the masked HPC3 AND chain: fresh-randomness count,
// share-pair indexing into the r/p vectors, and tap index width.
package masked_hpc3_and_chain_pkg;

    function automatic int num_quad(input int shares);
        return shares * (shares - 1) / 2;
    endfunction

    // Both orderings of a share pair map to the same slot so that r_ij == r_ji and p_ij == p_ji.
    function automatic int pair_idx(input int shares, input int i, input int j);
        int lo;
        int hi;
        lo = (i < j) ? i : j;
        hi = (i < j) ? j : i;
        if (lo == hi) begin
            return 0;
        end
        return lo * shares - (lo * (lo + 1)) / 2 + (hi - lo - 1);
    endfunction

    function automatic int tap_width(input int stages);
        return (stages < 2) ? 1 : $clog2(stages);
    endfunction

endpackage

// File: rtl/masked_hpc3_and_chain_mul.sv
// First-order HPC3 masked multiplier (lane-wise AND of two sharings), one register stage.
// DELAY_BR=1 accepts b and r one cycle ahead of a and registers b^r before use.
module masked_hpc3_1_mul_skewed
    import masked_hpc3_and_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int DELAY_BR   = 1,
    localparam int NUM_QUAD  = num_quad(NUM_SHARES)
) (
    input  logic                                in_clock,
    input  logic                                in_reset,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_b,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_r,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_c
);

    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] w_x;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] r_u;
    logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] r_v;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                 w_b;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                 r_ab;
    logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]                   w_r;

    generate
        if (DELAY_BR != 0) begin : g_skew
            logic [NUM_SHARES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] r_x;
            logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                 r_b;
            logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]                   r_r;

            always_ff @(posedge in_clock or negedge in_reset) begin
                if (!in_reset) begin
                    r_x <= '0;
                    r_b <= '0;
                    r_r <= '0;
                end else begin
                    for (int i = 0; i < NUM_SHARES; i++) begin
                        for (int j = 0; j < NUM_SHARES; j++) begin
                            if (i == j) begin
                                r_x[i][j] <= '0;
                            end else begin
                                r_x[i][j] <= in_b[j] ^ in_r[pair_idx(NUM_SHARES, i, j)];
                            end
                        end
                    end
                    r_b <= in_b;
                    r_r <= in_r;
                end
            end

            assign w_x = r_x;
            assign w_b = r_b;
            assign w_r = r_r;
        end else begin : g_direct
            always_comb begin
                w_x = '0;
                for (int i = 0; i < NUM_SHARES; i++) begin
                    for (int j = 0; j < NUM_SHARES; j++) begin
                        if (i != j) begin
                            w_x[i][j] = in_b[j] ^ in_r[pair_idx(NUM_SHARES, i, j)];
                        end
                    end
                end
            end

            assign w_b = in_b;
            assign w_r = in_r;
        end
    endgenerate

    // Every partial product is registered before any share compression to stop glitch leakage.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_ab <= '0;
            r_u  <= '0;
            r_v  <= '0;
        end else begin
            for (int i = 0; i < NUM_SHARES; i++) begin
                r_ab[i] <= in_a[i] & w_b[i];
                for (int j = 0; j < NUM_SHARES; j++) begin
                    if (i == j) begin
                        r_u[i][j] <= '0;
                        r_v[i][j] <= '0;
                    end else begin
                        r_u[i][j] <= in_a[i] & w_x[i][j];
                        r_v[i][j] <= (~in_a[i] & w_r[pair_idx(NUM_SHARES, i, j)])
                                     ^ in_p[pair_idx(NUM_SHARES, i, j)];
                    end
                end
            end
        end
    end

    always_comb begin
        out_c = r_ab;
        for (int i = 0; i < NUM_SHARES; i++) begin
            for (int j = 0; j < NUM_SHARES; j++) begin
                out_c[i] = out_c[i] ^ r_u[i][j] ^ r_v[i][j];
            end
        end
    end

endmodule

module masked_hpc3_1_mul
    import masked_hpc3_and_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    localparam int NUM_QUAD  = num_quad(NUM_SHARES)
) (
    input  logic                                in_clock,
    input  logic                                in_reset,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_a,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] in_b,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_r,
    input  logic [NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_p,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] out_c
);

    masked_hpc3_1_mul_skewed #(
        .NUM_SHARES(NUM_SHARES),
        .BIT_WIDTH (BIT_WIDTH),
        .DELAY_BR  (0)
    ) u_core (
        .in_clock(in_clock),
        .in_reset(in_reset),
        .in_a    (in_a),
        .in_b    (in_b),
        .in_r    (in_r),
        .in_p    (in_p),
        .out_c   (out_c)
    );

endmodule

// File: rtl/masked_hpc3_and_chain_sched.sv
// Exit-slot scheduler: books one exit cycle per token and tracks valid/tap tags down the chain.
module masked_hpc3_exit_scheduler
    import masked_hpc3_and_chain_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    localparam int TAP_W     = tap_width(NUM_STAGES)
) (
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_valid,
    input  logic [TAP_W-1:0] in_tap,
    output logic             out_ready,
    output logic             out_valid,
    output logic [TAP_W-1:0] out_tap
);

    logic [NUM_STAGES-1:0]            r_res;
    logic [NUM_STAGES-1:0]            w_resShift;
    logic [NUM_STAGES-1:0]            w_tapHot;
    logic [NUM_STAGES-1:0]            r_vld;
    logic [NUM_STAGES-1:0][TAP_W-1:0] r_tag;
    logic                             w_accept;

    assign w_resShift = r_res >> 1;

    // Out-of-range taps match no slot, so they are never ready.
    always_comb begin
        out_ready = 1'b0;
        w_tapHot  = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (in_tap == TAP_W'(i)) begin
                out_ready   = ~w_resShift[i];
                w_tapHot[i] = 1'b1;
            end
        end
    end

    assign w_accept = in_valid & out_ready;

    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            r_res <= '0;
            r_vld <= '0;
            r_tag <= '0;
        end else begin
            r_res    <= w_resShift | (w_accept ? w_tapHot : '0);
            r_vld    <= {r_vld[NUM_STAGES-2:0], w_accept};
            r_tag[0] <= in_tap;
            for (int i = 1; i < NUM_STAGES; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    // A token leaves when its age equals its tap; reservations guarantee at most one match.
    always_comb begin
        out_valid = 1'b0;
        out_tap   = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (r_vld[i] && (r_tag[i] == TAP_W'(i))) begin
                out_valid = 1'b1;
                out_tap   = r_tag[i];
            end
        end
    end

endmodule

// File: rtl/masked_hpc3_and_chain.sv
// Chain of NUM_STAGES HPC3 multipliers computing a & b_0 & ... & b_j, with per-token
// output tap selection and a collision-free exit schedule.
module masked_hpc3_and_chain
    import masked_hpc3_and_chain_pkg::*;
#(
    parameter int NUM_SHARES = 2,
    parameter int BIT_WIDTH  = 1,
    parameter int NUM_STAGES = 4,
    localparam int NUM_QUAD  = num_quad(NUM_SHARES),
    localparam int TAP_W     = tap_width(NUM_STAGES)
) (
    input  logic                                                in_clock,
    input  logic                                                in_reset,
    input  logic                                                in_valid,
    output logic                                                in_ready,
    input  logic [TAP_W-1:0]                                    in_tap,
    input  logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                in_a,
    input  logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] in_b,
    input  logic [NUM_STAGES-1:0][NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_r,
    input  logic [NUM_STAGES-1:0][NUM_QUAD-1:0][BIT_WIDTH-1:0]   in_p,
    output logic                                                out_valid,
    output logic [TAP_W-1:0]                                    out_tap,
    output logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                out_d
);

    logic [NUM_STAGES-1:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] w_d;
    logic [NUM_SHARES-1:0][BIT_WIDTH-1:0]                 w_sel;

    masked_hpc3_exit_scheduler #(
        .NUM_STAGES(NUM_STAGES)
    ) u_sched (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_valid (in_valid),
        .in_tap   (in_tap),
        .out_ready(in_ready),
        .out_valid(out_valid),
        .out_tap  (out_tap)
    );

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                masked_hpc3_1_mul #(
                    .NUM_SHARES(NUM_SHARES),
                    .BIT_WIDTH (BIT_WIDTH)
                ) u_mul (
                    .in_clock(in_clock),
                    .in_reset(in_reset),
                    .in_a    (in_a),
                    .in_b    (in_b[0]),
                    .in_r    (in_r[0]),
                    .in_p    (in_p[0]),
                    .out_c   (w_d[0])
                );
            end else begin : g_tail
                logic [NUM_SHARES-1:0][BIT_WIDTH-1:0] w_bk;

                // b_k waits k-1 cycles so it meets its token's a one cycle before the multiply.
                if (k == 1) begin : g_noline
                    assign w_bk = in_b[k];
                end else begin : g_line
                    logic [k-2:0][NUM_SHARES-1:0][BIT_WIDTH-1:0] r_line;

                    always_ff @(posedge in_clock or negedge in_reset) begin
                        if (!in_reset) begin
                            r_line <= '0;
                        end else begin
                            r_line[0] <= in_b[k];
                            for (int d = 1; d < k - 1; d++) begin
                                r_line[d] <= r_line[d-1];
                            end
                        end
                    end

                    assign w_bk = r_line[k-2];
                end

                masked_hpc3_1_mul_skewed #(
                    .NUM_SHARES(NUM_SHARES),
                    .BIT_WIDTH (BIT_WIDTH),
                    .DELAY_BR  (1)
                ) u_mul (
                    .in_clock(in_clock),
                    .in_reset(in_reset),
                    .in_a    (w_d[k-1]),
                    .in_b    (w_bk),
                    .in_r    (in_r[k]),
                    .in_p    (in_p[k]),
                    .out_c   (w_d[k])
                );
            end
        end
    endgenerate

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (out_tap == TAP_W'(k)) begin
                w_sel = w_d[k];
            end
        end
        out_d = out_valid ? w_sel : '0;
    end

endmodule

// File: tb/tb_masked_hpc3_and_chain.sv
// Directed bench for masked_hpc3_and_chain: fresh random sharings and r/p every cycle,
// expected results from hand-computed unmasked AND chains.
module tb_masked_hpc3_and_chain;

    logic                 in_clock = 1'b0;
    logic                 in_reset;
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_tap;
    logic [1:0][7:0]      in_a;
    logic [3:0][1:0][7:0] in_b;
    logic [3:0][0:0][7:0] in_r;
    logic [3:0][0:0][7:0] in_p;
    logic                 out_valid;
    logic [1:0]           out_tap;
    logic [1:0][7:0]      out_d;

    logic                 v3;
    logic [1:0]           tap3;
    logic                 ready3;
    logic                 outValid3;
    logic [1:0]           outTap3;
    logic [1:0][7:0]      outD3;
    logic [2:0][1:0][7:0] b3;
    logic [2:0][0:0][7:0] r3;
    logic [2:0][0:0][7:0] p3;

    logic [7:0] aPlain;
    logic [7:0] bPlain [4];
    logic [7:0] expPrev;
    int         checks   = 0;
    int         failures = 0;

    assign b3 = in_b[2:0];
    assign r3 = in_r[2:0];
    assign p3 = in_p[2:0];

    always #5 in_clock = ~in_clock;

    masked_hpc3_and_chain #(
        .NUM_SHARES(2),
        .BIT_WIDTH (8),
        .NUM_STAGES(4)
    ) dut (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tap   (in_tap),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_r     (in_r),
        .in_p     (in_p),
        .out_valid(out_valid),
        .out_tap  (out_tap),
        .out_d    (out_d)
    );

    // Three-stage instance so that an out-of-range tap value is representable on the port.
    masked_hpc3_and_chain #(
        .NUM_SHARES(2),
        .BIT_WIDTH (8),
        .NUM_STAGES(3)
    ) dut3 (
        .in_clock (in_clock),
        .in_reset (in_reset),
        .in_valid (v3),
        .in_ready (ready3),
        .in_tap   (tap3),
        .in_a     (in_a),
        .in_b     (b3),
        .in_r     (r3),
        .in_p     (p3),
        .out_valid(outValid3),
        .out_tap  (outTap3),
        .out_d    (outD3)
    );

    task automatic driveShares();
        logic [7:0] m;
        m       = 8'($urandom);
        in_a[0] = m;
        in_a[1] = aPlain ^ m;
        for (int k = 0; k < 4; k++) begin
            m          = 8'($urandom);
            in_b[k][0] = m;
            in_b[k][1] = bPlain[k] ^ m;
            in_r[k][0] = 8'($urandom);
            in_p[k][0] = 8'($urandom);
        end
    endtask

    task automatic nextCycle();
        @(posedge in_clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [1:0] tap);
        in_valid = v;
        in_tap   = tap;
        driveShares();
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [1:0] tap,
                             input logic [7:0] d);
        checkOutput({tag, ".valid"}, 16'(out_valid), 16'(v));
        if (v) begin
            checkOutput({tag, ".tap"}, 16'(out_tap), 16'(tap));
            checkOutput({tag, ".d"}, 16'(out_d[0] ^ out_d[1]), 16'(d));
        end else begin
            checkOutput({tag, ".dzero"}, out_d, 16'h0000);
        end
    endtask

    initial begin
        $display("[TB] start masked_hpc3_and_chain");
        in_reset = 1'b0;
        in_valid = 1'b0;
        in_tap   = 2'd0;
        v3       = 1'b0;
        tap3     = 2'd0;
        aPlain   = 8'h00;
        for (int k = 0; k < 4; k++) bPlain[k] = 8'h00;
        driveShares();
        #12;
        checkOutput("rst.ready", 16'(in_ready), 16'h1);
        checkOutput("rst.valid", 16'(out_valid), 16'h0);
        checkOutput("rst.tap", 16'(out_tap), 16'h0);
        checkOutput("rst.d", out_d, 16'h0000);
        checkOutput("rst.ready3", 16'(ready3), 16'h1);
        checkOutput("rst.tap3", 16'(outTap3), 16'h0);
        checkOutput("rst.d3", outD3, 16'h0000);
        in_reset = 1'b1;

        // Single tokens: tap 3 exits 4 cycles later, tap 1 exits 2 cycles later.
        aPlain = 8'hFF;
        bPlain[0] = 8'hF0; bPlain[1] = 8'h3C; bPlain[2] = 8'h0F; bPlain[3] = 8'hFF;
        nextCycle();
        applyStimulus(1'b1, 2'd3);
        checkOutput("t3.ready", 16'(in_ready), 16'h1);
        for (int i = 1; i <= 5; i++) begin
            nextCycle();
            applyStimulus(1'b0, 2'd0);
            expectOut($sformatf("t3.c%0d", i), i == 4, 2'd3, 8'h00);
        end
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("t1.ready", 16'(in_ready), 16'h1);
        for (int i = 1; i <= 3; i++) begin
            nextCycle();
            applyStimulus(1'b0, 2'd0);
            expectOut($sformatf("t1.c%0d", i), i == 2, 2'd1, 8'h30);
        end

        // Back-to-back tap 0 with a changing a operand.
        bPlain[0] = 8'hF3;
        expPrev   = 8'h00;
        for (int i = 0; i <= 10; i++) begin
            nextCycle();
            aPlain = 8'(i * 37 + 5);
            applyStimulus(i < 10, 2'd0);
            if (i < 10) checkOutput($sformatf("s0.ready%0d", i), 16'(in_ready), 16'h1);
            if (i > 0) expectOut($sformatf("s0.out%0d", i), 1'b1, 2'd0, expPrev);
            expPrev = aPlain & bPlain[0];
        end
        nextCycle();
        applyStimulus(1'b0, 2'd0);
        expectOut("s0.drain", 1'b0, 2'd0, 8'h00);

        // Slot collision: tap 2 then tap 1 would exit together, so tap 1 waits one cycle.
        aPlain = 8'hFF;
        bPlain[0] = 8'hF7; bPlain[1] = 8'h7E; bPlain[2] = 8'h3F; bPlain[3] = 8'hFF;
        nextCycle();
        applyStimulus(1'b1, 2'd2);
        checkOutput("col.readyA", 16'(in_ready), 16'h1);
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("col.blockB", 16'(in_ready), 16'h0);
        expectOut("col.t1", 1'b0, 2'd0, 8'h00);
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("col.readyB", 16'(in_ready), 16'h1);
        expectOut("col.t2", 1'b0, 2'd0, 8'h00);
        nextCycle();
        applyStimulus(1'b0, 2'd0);
        expectOut("col.t3", 1'b1, 2'd2, 8'h36);
        nextCycle();
        applyStimulus(1'b0, 2'd0);
        expectOut("col.t4", 1'b1, 2'd1, 8'h76);
        nextCycle();
        applyStimulus(1'b0, 2'd0);
        expectOut("col.t5", 1'b0, 2'd0, 8'h00);

        // Out-of-range tap on the three-stage instance is never accepted.
        v3   = 1'b1;
        tap3 = 2'd3;
        for (int i = 0; i < 8; i++) begin
            nextCycle();
            applyStimulus(1'b0, 2'd0);
            if (i == 3) v3 = 1'b0;
            if (i < 3) checkOutput($sformatf("ill.ready%0d", i), 16'(ready3), 16'h0);
            checkOutput($sformatf("ill.valid%0d", i), 16'(outValid3), 16'h0);
        end
        tap3 = 2'd2;
        #1;
        checkOutput("ill.legalReady", 16'(ready3), 16'h1);

        // Reset with tokens in flight, one of them exiting at that moment.
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("rmf.ready0", 16'(in_ready), 16'h1);
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("rmf.ready1", 16'(in_ready), 16'h1);
        nextCycle();
        applyStimulus(1'b1, 2'd1);
        checkOutput("rmf.ready2", 16'(in_ready), 16'h1);
        expectOut("rmf.exit0", 1'b1, 2'd1, 8'h76);
        nextCycle();
        applyStimulus(1'b0, 2'd0);
        expectOut("rmf.exit1", 1'b1, 2'd1, 8'h76);
        in_reset = 1'b0;
        #1;
        checkOutput("rmf.valid", 16'(out_valid), 16'h0);
        checkOutput("rmf.d", out_d, 16'h0000);
        checkOutput("rmf.ready", 16'(in_ready), 16'h1);
        #2;
        in_reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b0, 2'd0);
            expectOut($sformatf("rmf.stale%0d", i), 1'b0, 2'd0, 8'h00);
        end

        // Fixed unmasked operands, fresh shares and randomness each run.
        aPlain = 8'hE7;
        bPlain[0] = 8'hFD; bPlain[1] = 8'h7F; bPlain[2] = 8'hBE; bPlain[3] = 8'hF6;
        for (int i = 0; i < 1004; i++) begin
            nextCycle();
            applyStimulus(i < 1000, 2'd3);
            if (i >= 4) expectOut($sformatf("rnd.%0d", i - 4), 1'b1, 2'd3, 8'h24);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
